// File: rtl/alarm_ringer.sv
// Alarm ringer FSM: IDLE / RINGING / SNOOZE sequencing driven by a one-second tick.
// The snooze feature is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_ringer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       alarm_on,
  input  logic       alarm_match,
  input  logic       snooze_key,
  input  logic       stop_key,
  output logic       play_sound,
  output logic       snoozing,
  output logic [2:0] snooze_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RINGING = 2'd1;
  localparam logic [9:0] RING_LAST = 10'(RING_SECS - 1);
`ifdef ALARM_SNOOZE_EN
  localparam logic [1:0] SNOOZE    = 2'd2;
  localparam logic [9:0] SNZ_LAST  = 10'(SNOOZE_SECS - 1);
  localparam logic [2:0] SNZ_MAX   = 3'(MAX_SNOOZE);
`endif

  logic [1:0] state, state_nxt;
  logic [9:0] sec_cnt, sec_cnt_nxt;
  logic       match_q;
  logic       trigger;
`ifdef ALARM_SNOOZE_EN
  logic [2:0] snz_cnt, snz_cnt_nxt;
`endif

  // Rising edge of alarm_match only; a match held across reset release is not an edge.
  assign trigger = alarm_match & ~match_q;

  always_comb begin
    state_nxt   = state;
    sec_cnt_nxt = sec_cnt;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_nxt = snz_cnt;
`endif
    if (!alarm_on) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state_nxt = RINGING;
          end
        end
        RINGING: begin
          if (stop_key) begin
            state_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze_key && (snz_cnt < SNZ_MAX)) begin
            state_nxt   = SNOOZE;
            snz_cnt_nxt = snz_cnt + 3'd1;
`endif
          end else if (sec_tick) begin
            if (sec_cnt == RING_LAST) state_nxt = IDLE;
            else                      sec_cnt_nxt = sec_cnt + 10'd1;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stop_key) begin
            state_nxt = IDLE;
          end else if (sec_tick) begin
            if (sec_cnt == SNZ_LAST) state_nxt = RINGING;
            else                     sec_cnt_nxt = sec_cnt + 10'd1;
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
    // Every state change restarts the second counter, so it can never wrap.
    if (state_nxt != state) sec_cnt_nxt = '0;
`ifdef ALARM_SNOOZE_EN
    if (state_nxt == IDLE) snz_cnt_nxt = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sec_cnt <= '0;
      match_q <= 1'b1;
`ifdef ALARM_SNOOZE_EN
      snz_cnt <= '0;
`endif
    end else begin
      state   <= state_nxt;
      sec_cnt <= sec_cnt_nxt;
      match_q <= alarm_match;
`ifdef ALARM_SNOOZE_EN
      snz_cnt <= snz_cnt_nxt;
`endif
    end
  end

  assign play_sound = (state == RINGING);
`ifdef ALARM_SNOOZE_EN
  assign snoozing     = (state == SNOOZE);
  assign snooze_count = snz_cnt;
`else
  logic unused_snooze;
  assign unused_snooze = ^{snooze_key, 10'(SNOOZE_SECS), 3'(MAX_SNOOZE)};
  assign snoozing      = 1'b0;
  assign snooze_count  = 3'd0;
`endif

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer with RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2.
// Snooze scenarios are selected by ALARM_SNOOZE_EN to match the build under test.
module tb_alarm_ringer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0;
  logic       alarm_on = 1'b1;
  logic       alarm_match = 1'b0;
  logic       snooze_key = 1'b0;
  logic       stop_key = 1'b0;
  logic       play_sound;
  logic       snoozing;
  logic [2:0] snooze_count;
  logic [4:0] obs;

  int checks = 0;
  int errors = 0;

  alarm_ringer #(.RING_SECS(4), .SNOOZE_SECS(3), .MAX_SNOOZE(2)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .alarm_on(alarm_on),
    .alarm_match(alarm_match), .snooze_key(snooze_key), .stop_key(stop_key),
    .play_sound(play_sound), .snoozing(snoozing), .snooze_count(snooze_count)
  );

  always #5 clk = ~clk;

  // {play_sound, snoozing, snooze_count}
  assign obs = {play_sound, snoozing, snooze_count};

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sec(input int n = 1);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1; tick(); sec_tick = 1'b0;
    end
  endtask

  task automatic press_snooze();
    snooze_key = 1'b1; tick(); snooze_key = 1'b0;
  endtask

  task automatic start_ring();
    alarm_match = 1'b0; tick();
    alarm_match = 1'b1; tick();
    alarm_match = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; alarm_on = 1'b1; alarm_match = 1'b1;
    tick(2);
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL reset_state: got %b want %b", obs, 5'b00000); end
    reset = 1'b0;
    tick(3);
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL match_at_release: got %b want %b", obs, 5'b00000); end
    alarm_match = 1'b0; tick();
  endtask

  task automatic test_ring_timeout();
    start_ring();
    checks++; if (obs !== 5'b10000) begin errors++; $display("FAIL ring_start: got %b want %b", obs, 5'b10000); end
    pulse_sec(3);
    checks++; if (obs !== 5'b10000) begin errors++; $display("FAIL ring_3s: got %b want %b", obs, 5'b10000); end
    pulse_sec();
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL ring_timeout: got %b want %b", obs, 5'b00000); end
  endtask

  task automatic test_alarm_off_no_ring();
    alarm_on = 1'b0;
    start_ring();
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL off_no_ring: got %b want %b", obs, 5'b00000); end
    alarm_on = 1'b1; tick();
  endtask

  task automatic test_retrigger_ignored();
    start_ring();
    pulse_sec(2);
    start_ring();
    pulse_sec();
    checks++; if (obs !== 5'b10000) begin errors++; $display("FAIL retrig_3s: got %b want %b", obs, 5'b10000); end
    pulse_sec();
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL retrig_timeout: got %b want %b", obs, 5'b00000); end
  endtask

  task automatic test_stop_and_snooze_same_cycle();
    start_ring();
    stop_key = 1'b1; snooze_key = 1'b1; tick();
    stop_key = 1'b0; snooze_key = 1'b0;
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL stop_over_snooze: got %b want %b", obs, 5'b00000); end
  endtask

  task automatic test_alarm_off_mid_ring();
    start_ring();
    alarm_on = 1'b0; stop_key = 1'b0; sec_tick = 1'b1; tick();
    sec_tick = 1'b0;
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL off_mid_ring: got %b want %b", obs, 5'b00000); end
    alarm_on = 1'b1; tick();
  endtask

  task automatic test_reset_mid_ring();
    start_ring();
    pulse_sec();
    reset = 1'b1; tick();
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL reset_mid_ring: got %b want %b", obs, 5'b00000); end
    reset = 1'b0; tick();
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL after_reset_release: got %b want %b", obs, 5'b00000); end
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic test_snooze_cycle();
    start_ring();
    press_snooze();
    checks++; if (obs !== 5'b01001) begin errors++; $display("FAIL snooze1: got %b want %b", obs, 5'b01001); end
    pulse_sec(2);
    checks++; if (obs !== 5'b01001) begin errors++; $display("FAIL snooze1_2s: got %b want %b", obs, 5'b01001); end
    pulse_sec();
    checks++; if (obs !== 5'b10001) begin errors++; $display("FAIL resume1: got %b want %b", obs, 5'b10001); end
    press_snooze();
    checks++; if (obs !== 5'b01010) begin errors++; $display("FAIL snooze2: got %b want %b", obs, 5'b01010); end
    pulse_sec(3);
    checks++; if (obs !== 5'b10010) begin errors++; $display("FAIL resume2: got %b want %b", obs, 5'b10010); end
    press_snooze();
    checks++; if (obs !== 5'b10010) begin errors++; $display("FAIL snooze3_ignored: got %b want %b", obs, 5'b10010); end
    pulse_sec(3);
    checks++; if (obs !== 5'b10010) begin errors++; $display("FAIL ring_after_max_3s: got %b want %b", obs, 5'b10010); end
    pulse_sec();
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL timeout_clears_count: got %b want %b", obs, 5'b00000); end
  endtask

  task automatic test_snooze_abort();
    start_ring();
    press_snooze();
    pulse_sec();
    alarm_on = 1'b0; tick();
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL off_mid_snooze: got %b want %b", obs, 5'b00000); end
    alarm_on = 1'b1; tick();
    start_ring();
    press_snooze();
    stop_key = 1'b1; sec_tick = 1'b1; tick();
    stop_key = 1'b0; sec_tick = 1'b0;
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL stop_mid_snooze: got %b want %b", obs, 5'b00000); end
  endtask
`else
  task automatic test_snooze_disabled();
    start_ring();
    press_snooze();
    checks++; if (obs !== 5'b10000) begin errors++; $display("FAIL snooze_ignored: got %b want %b", obs, 5'b10000); end
    pulse_sec(3);
    checks++; if (obs !== 5'b10000) begin errors++; $display("FAIL nosnz_3s: got %b want %b", obs, 5'b10000); end
    pulse_sec();
    checks++; if (obs !== 5'b00000) begin errors++; $display("FAIL nosnz_timeout: got %b want %b", obs, 5'b00000); end
  endtask
`endif

  initial begin
    test_reset();
    test_ring_timeout();
    test_alarm_off_no_ring();
    test_retrigger_ignored();
    test_stop_and_snooze_same_cycle();
    test_alarm_off_mid_ring();
`ifdef ALARM_SNOOZE_EN
    test_snooze_cycle();
    test_snooze_abort();
`else
    test_snooze_disabled();
`endif
    test_reset_mid_ring();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ringer.md
ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
REQ-001 Parameter RING_SECS, default 60, ring duration in sec_tick pulses before auto-stop (range 1..255).
REQ-002 Parameter SNOOZE_SECS, default 300, snooze duration in sec_tick pulses (range 1..1023).
REQ-003 Parameter MAX_SNOOZE, default 3, maximum snoozes per alarm event (range 1..7).
REQ-004 clk  input  1  system clock; the only clock; sec_tick is synchronous to it.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sec_tick  input  1  one-clk-wide pulse, once per second.
REQ-007 alarm_on  input  1  alarm enable switch (level).
REQ-008 alarm_match  input  1  current time equals alarm time (level, high for one whole second).
REQ-009 snooze_key  input  1  one-clk-wide snooze key pulse from the keyboard key controller.
REQ-010 stop_key  input  1  one-clk-wide stop key pulse.
REQ-011 play_sound  output  1  high while RINGING; drives the song player playSound input.
REQ-012 snoozing  output  1  high while SNOOZE.
REQ-013 snooze_count  output  3  snoozes taken in the current alarm event.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RINGING, SNOOZE; all outputs are decoded from registered state/counters (no input-to-output combinational path).
REQ-015 The block SHALL register alarm_match into match_q each clk; trigger = alarm_match & ~match_q.
REQ-016 IDLE -> RINGING SHALL occur on the edge where trigger=1 and alarm_on=1; play_sound is high from the following cycle (1-cycle latency).
REQ-017 On RINGING entry the second counter SHALL load 0; each sec_tick increments it; a sec_tick with counter = RING_SECS-1 SHALL move RINGING -> IDLE (timeout).
REQ-018 In RINGING, snooze_key with snooze_count < MAX_SNOOZE SHALL move to SNOOZE, increment snooze_count, clear the counter; with snooze_count = MAX_SNOOZE snooze_key SHALL be ignored.
REQ-019 In SNOOZE, a sec_tick with counter = SNOOZE_SECS-1 SHALL move to RINGING with counter cleared.
REQ-020 stop_key in RINGING or SNOOZE SHALL move to IDLE.
REQ-021 alarm_on = 0 SHALL force IDLE on the next edge from any state, overriding all other events.
REQ-022 Same-cycle priority: alarm_on=0 > stop_key > snooze_key > sec_tick timeout/expiry.
REQ-023 snooze_count SHALL clear to 0 on every entry to IDLE and never exceed MAX_SNOOZE.
REQ-024 trigger SHALL be ignored in RINGING and SNOOZE (no restart, no counter reload).
REQ-025 Counter width SHALL be 10 bits; it SHALL never wrap (cleared on every state change).

Reset
REQ-026 reset SHALL force state IDLE, counter 0, snooze_count 0, play_sound 0, snoozing 0.
REQ-027 match_q SHALL reset to 1, so alarm_match already high at reset release does not trigger.
REQ-028 reset SHALL take priority over every other input, including mid-ring or mid-snooze.

Configuration
REQ-029 Macro ALARM_SNOOZE_EN: defined -> snooze behaviour per REQ-018/019; undefined -> SNOOZE state absent, snooze_key ignored, snoozing and snooze_count tied to 0.

Verification (RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2, ALARM_SNOOZE_EN defined unless noted)
REQ-030 alarm_on=1, alarm_match 0->1 -> play_sound=1 one cycle later; after 4 sec_ticks play_sound=0, state IDLE.
REQ-031 Ringing, snooze_key -> snoozing=1, snooze_count=1, play_sound=0; after 3 sec_ticks play_sound=1 again.
REQ-032 Three snooze_key presses across ringing periods -> snooze_count stays 2, third press ignored, play_sound stays 1.
REQ-033 Ringing, stop_key and snooze_key in same cycle -> IDLE, snooze_count=0; alarm_on dropped mid-snooze -> IDLE next edge.
REQ-034 reset released with alarm_match=1 -> no ring; reset asserted mid-ring -> all outputs 0 next edge.
REQ-035 ALARM_SNOOZE_EN undefined: ringing, snooze_key -> no effect, play_sound stays 1 until timeout.
